// File: rtl/keccak_pkg.sv
// Row-level Keccak chi helpers shared by the inverse-chi datapath.
// The inverse row table is a constant derived from the forward map at elaboration.
package keccak_pkg;

  localparam int ROW_SIZE = 5;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} chi_inv_state_e;

  function automatic logic [ROW_SIZE-1:0] chi_row_fwd(input logic [ROW_SIZE-1:0] a);
    logic [ROW_SIZE-1:0] o;
    o = '0;
    for (int i = 0; i < ROW_SIZE; i++) begin
      o[i] = a[i] ^ (~a[(i+1) % ROW_SIZE] & a[(i+2) % ROW_SIZE]);
    end
    return o;
  endfunction

  // Entry k of the packed table holds the preimage of k under chi_row_fwd.
  function automatic logic [32*ROW_SIZE-1:0] build_inv_table();
    logic [32*ROW_SIZE-1:0] t;
    t = '0;
    for (int v = 0; v < 32; v++) begin
      t[ROW_SIZE*int'(chi_row_fwd(5'(v))) +: ROW_SIZE] = 5'(v);
    end
    return t;
  endfunction

  localparam logic [32*ROW_SIZE-1:0] INV_TABLE = build_inv_table();

  function automatic logic [ROW_SIZE-1:0] chi_row_inv(input logic [ROW_SIZE-1:0] b);
    return INV_TABLE[ROW_SIZE*int'(b) +: ROW_SIZE];
  endfunction

endpackage

// File: rtl/chi_inv_row.sv
// Combinational inverse of chi on a single 5-bit row.
// Pure table lookup, no state.
module chi_inv_row
  import keccak_pkg::*;
(
  input  logic [ROW_SIZE-1:0] row_i,
  output logic [ROW_SIZE-1:0] row_o
);

  assign row_o = chi_row_inv(row_i);

endmodule

// File: rtl/chi_inv_state.sv
// Iterative inverse chi over a 25-lane state, ROWS_PER_CYCLE rows per clock.
// Result appears 5W/RPC+1 cycles after acceptance; one state in flight, held in DONE until out_ready.
module chi_inv_state
  import keccak_pkg::*;
#(
  parameter int W              = 64,
  parameter int ROWS_PER_CYCLE = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [25*W-1:0] in_state,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [25*W-1:0] out_state,
  output logic          busy
);

  localparam int RPC = ROWS_PER_CYCLE;
  localparam int N   = 5 * W / RPC;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  if ((5 * W) % RPC != 0) begin : g_bad_rpc
    $error("ROWS_PER_CYCLE must divide 5*W");
  end

  chi_inv_state_e  state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fin_q, fin_d;
  logic [25*W-1:0] work_q, work_d;
  logic [ROW_SIZE-1:0] rows_in  [RPC];
  logic [ROW_SIZE-1:0] rows_out [RPC];

  for (genvar j = 0; j < RPC; j++) begin : g_row
    chi_inv_row u_row (
      .row_i (rows_in[j]),
      .row_o (rows_out[j])
    );
  end

  // Row r lives at lanes (0..4, r/W), bit r%W; chunk r/RPC feeds inverter r%RPC.
  always_comb begin
    for (int j = 0; j < RPC; j++) rows_in[j] = '0;
    for (int r = 0; r < 5 * W; r++) begin
      if (cnt_q == CW'(r / RPC)) begin
        for (int i = 0; i < ROW_SIZE; i++) begin
          rows_in[r % RPC][i] = work_q[W * (5 * (r / W) + i) + (r % W)];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fin_d     = fin_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = '0;
          fin_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        // One extra BUSY cycle after the last chunk before presenting the result.
        if (fin_q) begin
          state_d = DONE;
        end else begin
          for (int r = 0; r < 5 * W; r++) begin
            if (cnt_q == CW'(r / RPC)) begin
              for (int i = 0; i < ROW_SIZE; i++) begin
                work_d[W * (5 * (r / W) + i) + (r % W)] = rows_out[r % RPC][i];
              end
            end
          end
          if (cnt_q == CW'(N - 1)) fin_d = 1'b1;
          else                     cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      work_q  <= work_d;
    end
  end

  assign out_state = work_q;

endmodule

// File: tb/tb_chi_inv_state.sv
// Scoreboard bench for chi_inv_state: expected states are queued at issue, a monitor checks each output.
module tb_chi_inv_state;

  localparam int W   = 64;
  localparam int RPC = 20;
  localparam int N   = 5 * W / RPC;
  localparam int SW  = 25 * W;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_state  = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [SW-1:0] out_state;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [SW-1:0] exp_q [$];

  always #5 clk = ~clk;

  chi_inv_state #(.W(W), .ROWS_PER_CYCLE(RPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  function automatic logic [SW-1:0] chi_fwd_model(input logic [SW-1:0] s);
    logic [W-1:0]  a [5][5];
    logic [SW-1:0] r;
    r = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) a[x][y] = s[W*(5*y+x) +: W];
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[W*(5*y+x) +: W] = a[x][y] ^ (~a[(x+1)%5][y] & a[(x+2)%5][y]);
    return r;
  endfunction

  function automatic logic [4:0] fwd5(input logic [4:0] v);
    logic [4:0] o;
    for (int i = 0; i < 5; i++) o[i] = v[i] ^ (~v[(i+1)%5] & v[(i+2)%5]);
    return o;
  endfunction

  function automatic int first_diff_lane(input logic [SW-1:0] a, input logic [SW-1:0] b);
    for (int l = 0; l < 25; l++) if (a[W*l +: W] !== b[W*l +: W]) return l;
    return 0;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] s;
    for (int k = 0; k < SW / 32; k++) s[32*k +: 32] = $urandom;
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic check_state(input string name, input logic [SW-1:0] got, input logic [SW-1:0] want);
    int l;
    n_tests++;
    if (got !== want) begin
      n_fail++;
      l = first_diff_lane(got, want);
      $display("FAIL %s: lane %0d got %h, want %h", name, l, got[W*l +: W], want[W*l +: W]);
    end
  endtask

  // Monitor: every transfer on the output handshake pops one expected state.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got a transfer, want none pending");
      end else begin
        check_state("out_state", out_state, exp_q.pop_front());
      end
    end
  end

  // All tasks start and end #1 after a rising edge.
  task automatic send(input logic [SW-1:0] x, input logic [SW-1:0] e, output bit ok);
    ok = 1'b0;
    in_state = x;
    in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      exp_q.push_back(e);
      @(posedge clk); #1;
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, want 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input string name, input logic [SW-1:0] x, input logic [SW-1:0] e, input bit chk_lat);
    bit ok;
    int lat;
    send(x, e, ok);
    if (!ok) return;
    wait_out(lat);
    if (chk_lat || !out_valid) check({"latency_", name}, lat, N + 1);
    @(posedge clk); #1;
    if (chk_lat) check({"valid_drop_", name}, out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [SW-1:0] x, orig, snap;
    bit ok;
    int lat;

    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check_state("rst_out_state", out_state, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 32; v++) check("table_roundtrip", keccak_pkg::chi_row_inv(fwd5(5'(v))), v);

    run("zero", '0, '0, 1'b1);
    run("ones", '1, '1, 1'b1);

    // Row 0 with bits 1,0,0,1,0 inverts to 1,0,0,0,0.
    x = '0;
    x[0]     = 1'b1;
    x[W*3]   = 1'b1;
    orig     = '0;
    orig[0]  = 1'b1;
    run("row0", x, orig, 1'b1);

    // Rows z = 0..31 of plane y = 0 carry every 5-bit value once.
    orig = '0;
    for (int v = 0; v < 32; v++)
      for (int i = 0; i < 5; i++) orig[W*i + v] = 1'(v >> i);
    run("all32", chi_fwd_model(orig), orig, 1'b1);

    for (int k = 0; k < 200; k++) begin
      orig = rand_state();
      run("rand", chi_fwd_model(orig), orig, 1'b0);
    end

    // Backpressure in DONE with a competing input.
    out_ready = 1'b0;
    orig = rand_state();
    send(chi_fwd_model(orig), orig, ok);
    wait_out(lat);
    check("bp_latency", lat, N + 1);
    snap = out_state;
    in_state = ~orig;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check_state("bp_hold", out_state, snap);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_drop", out_valid, 0);
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("bp_no_second", {out_valid, busy}, 0);
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset in the middle of BUSY.
    orig = rand_state();
    send(chi_fwd_model(orig), orig, ok);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check_state("mid_rst_out_state", out_state, '0);
    if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_quiet", out_valid, 0);
    orig = rand_state();
    run("post_rst", chi_fwd_model(orig), orig, 1'b1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
